sequence_generator: RTL and testbench

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

---
 rtl/seq_gen_pkg.sv | 28 ++
 rtl/seq_down_counter.sv | 34 +++
 rtl/sequence_generator.sv | 189 ++++++++++++++++++
 tb/tb_sequence_generator.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_gen_pkg
// Description : Shared types and default sizes for the serial pattern
//               sequence generator.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_gen_pkg;

  // Default pattern length and counter width
  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 4;

  // Transmit controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width of a bit-index counter able to hold PAT_W-1
  function automatic int idx_width(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_down_counter
// Description : Loadable down counter with zero flag. Load has priority
//               over decrement.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Counter register: reset clears, load overrides decrement
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/sequence_generator.sv
`default_nettype none
// ============================================================================
// Module      : sequence_generator
// Description : Serializes a latched pattern MSB first, repeat_cnt times,
//               with gap_len zero bits between frames, then pulses done.
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [CNT_W-1:0] gap_len,
  output logic             out_bit,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = idx_width(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  state_t state, state_next;

  // Latched transmission parameters
  logic [PAT_W-1:0] pat_latched;
  logic [CNT_W-1:0] gap_latched;
  logic             latch;

  // Counter controls and status
  logic             bit_load, bit_dec, bit_zero;
  logic [IDX_W-1:0] bit_cnt;
  logic [IDX_W-1:0] bit_prev;
  logic             frm_load, frm_dec, frm_zero;
  logic [CNT_W-1:0] frm_cnt;
  logic [CNT_W-1:0] frm_load_val;
  logic             gap_load, gap_dec, gap_zero;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] gap_load_val;

  // Next values of the registered outputs
  logic out_bit_next, bit_valid_next, busy_next, done_next;

  // The frame and gap counters are only consulted through their zero flags
  logic unused_counts;
  assign unused_counts = ^{frm_cnt, gap_cnt};

  // bit_cnt holds the index of the bit currently on out_bit
  assign bit_prev     = bit_cnt - IDX_W'(1);
  // Frame and gap counters hold "remaining after the current one"
  assign frm_load_val = repeat_cnt - CNT_W'(1);
  assign gap_load_val = gap_latched - CNT_W'(1);

  seq_down_counter #(.WIDTH(IDX_W)) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (bit_load),
    .load_val (LAST_IDX),
    .dec      (bit_dec),
    .count    (bit_cnt),
    .zero     (bit_zero)
  );

  seq_down_counter #(.WIDTH(CNT_W)) u_frm_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (frm_load),
    .load_val (frm_load_val),
    .dec      (frm_dec),
    .count    (frm_cnt),
    .zero     (frm_zero)
  );

  seq_down_counter #(.WIDTH(CNT_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (gap_load_val),
    .dec      (gap_dec),
    .count    (gap_cnt),
    .zero     (gap_zero)
  );

  // State, latched parameters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pat_latched <= '0;
      gap_latched <= '0;
      out_bit     <= 1'b0;
      bit_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state     <= state_next;
      out_bit   <= out_bit_next;
      bit_valid <= bit_valid_next;
      busy      <= busy_next;
      done      <= done_next;
      if (latch) begin
        pat_latched <= pattern;
        gap_latched <= gap_len;
      end
    end
  end

  // Next-state, counter control and next-output decode
  always_comb begin
    state_next     = state;
    latch          = 1'b0;
    bit_load       = 1'b0;
    bit_dec        = 1'b0;
    frm_load       = 1'b0;
    frm_dec        = 1'b0;
    gap_load       = 1'b0;
    gap_dec        = 1'b0;
    out_bit_next   = 1'b0;
    bit_valid_next = 1'b0;
    busy_next      = 1'b0;
    done_next      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && (repeat_cnt != '0)) begin
          // MSB goes straight from the input so it appears next cycle
          latch          = 1'b1;
          bit_load       = 1'b1;
          frm_load       = 1'b1;
          state_next     = SEND;
          out_bit_next   = pattern[PAT_W-1];
          bit_valid_next = 1'b1;
          busy_next      = 1'b1;
        end
      end

      SEND: begin
        if (!bit_zero) begin
          bit_dec        = 1'b1;
          out_bit_next   = pat_latched[bit_prev];
          bit_valid_next = 1'b1;
          busy_next      = 1'b1;
        end else if (frm_zero) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          frm_dec        = 1'b1;
          bit_valid_next = 1'b1;
          busy_next      = 1'b1;
          if (gap_latched != '0) begin
            gap_load   = 1'b1;
            state_next = GAP;
          end else begin
            bit_load     = 1'b1;
            out_bit_next = pat_latched[PAT_W-1];
          end
        end
      end

      GAP: begin
        bit_valid_next = 1'b1;
        busy_next      = 1'b1;
        if (gap_zero) begin
          bit_load     = 1'b1;
          state_next   = SEND;
          out_bit_next = pat_latched[PAT_W-1];
        end else begin
          gap_dec = 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sequence_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequence_generator
// Description : Directed, scoreboard-based bench for sequence_generator.
//               Expected {out_bit, bit_valid, busy, done} per cycle is
//               queued when a request is driven and popped each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequence_generator;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic [CNT_W-1:0] gap_len = '0;
  logic             out_bit, bit_valid, busy, done;

  int checks = 0;
  int errors = 0;
  int dets;
  logic [3:0] expq[$];

  wire [3:0] obs = {out_bit, bit_valid, busy, done};

  sequence_generator #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .out_bit    (out_bit),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Reference model: per-cycle outputs for one request
  task automatic push_expected(input logic [PAT_W-1:0] pat, input int rc, input int gap,
                               input int idle_tail);
    for (int f = 0; f < rc; f++) begin
      for (int i = PAT_W - 1; i >= 0; i--) expq.push_back({pat[i], 3'b110});
      if (f < rc - 1) for (int g = 0; g < gap; g++) expq.push_back(4'b0110);
    end
    if (rc != 0) expq.push_back(4'b0001);
    for (int k = 0; k < idle_tail; k++) expq.push_back(4'b0000);
  endtask

  // Drive one request, then compare every cycle until the scoreboard drains.
  // Non-overlapping 1011 detector counts matches in the valid bit stream.
  task automatic run(input string tag, input logic [PAT_W-1:0] pat,
                     input logic [CNT_W-1:0] rc, input logic [CNT_W-1:0] gap,
                     input bit disturb, input bit release_reset, output int n_det);
    int cyc;
    int fill;
    logic [3:0] sh;
    logic [3:0] e;
    @(negedge clk);
    if (release_reset) reset = 1'b0;
    pattern    = pat;
    repeat_cnt = rc;
    gap_len    = gap;
    start      = 1'b1;
    push_expected(pat, int'(rc), int'(gap), (rc == 0) ? 10 : 2);
    cyc = 0; fill = 0; sh = '0; n_det = 0;
    while (expq.size() > 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      e = expq.pop_front();
      check($sformatf("%s_c%0d", tag, cyc), 32'(obs), 32'(e));
      if (bit_valid) begin
        sh = {sh[2:0], out_bit};
        fill++;
        if (fill >= 4 && sh == 4'b1011) begin
          n_det++;
          fill = 0;
        end
      end
      if (disturb && cyc == 1) begin
        start = 1'b1; pattern = ~pat; repeat_cnt = 4'hF; gap_len = 4'h3;
      end
      if (disturb && cyc == 2) start = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_state", 32'(obs), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check("reset_hold", 32'(obs), 32'h0);

    // Single frame, no gap
    run("p1011_r1", 4'b1011, 4'd1, 4'd0, 1'b0, 1'b0, dets);
    // Two frames with two-bit gap
    run("p1011_r2g2", 4'b1011, 4'd2, 4'd2, 1'b0, 1'b0, dets);
    // Three contiguous frames
    run("p0110_r3", 4'b0110, 4'd3, 4'd0, 1'b0, 1'b0, dets);
    // Zero repeat count: nothing happens
    run("rc0", 4'b1111, 4'd0, 4'd3, 1'b0, 1'b0, dets);
    // Input changes and start during transmission are ignored
    run("disturb", 4'b1100, 4'd2, 4'd1, 1'b1, 1'b0, dets);
    // Loopback into the 1011 detector
    run("loop", 4'b1011, 4'd2, 4'd1, 1'b0, 1'b0, dets);
    check("loop_detect_count", 32'(dets), 32'd2);
    // Maximum frames and gap length
    run("max", 4'b1001, 4'hF, 4'hF, 1'b0, 1'b0, dets);

    // Reset mid-transmission
    @(negedge clk);
    pattern = 4'b1011; repeat_cnt = 4'd2; gap_len = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid_c1", 32'(obs), 32'hE);
    @(negedge clk);
    check("rst_mid_c2", 32'(obs), 32'h6);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("rst_abort_c%0d", k), 32'(obs), 32'h0);
    end
    // Reset wins over start on the same edge
    start = 1'b1;
    @(negedge clk);
    check("rst_over_start", 32'(obs), 32'h0);
    // Start accepted on the first edge with reset low
    run("restart", 4'b1011, 4'd1, 4'd0, 1'b0, 1'b1, dets);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
